// File: rtl/router_mcast_arbiter.sv
// Switch allocator with atomic multicast, round-robin scan and an anti-starvation reservation FSM; stats under ROUTER_ARB_STATS_EN.
// Latency: 0 cycles (grant/out_valid/xbar_sel combinational from request and registered state).
// Backpressure: an input is granted only when every output in its destination set is ready and unclaimed.
module router_mcast_arbiter #(
  parameter int NPORTS         = 5,
  parameter int FLIT_W         = 64,
  parameter int MCAST_FLAG_BIT = 31,
  parameter int MCAST_MASK_LSB = 26,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS-1:0]          req_valid,
  input  logic [FLIT_W*NPORTS-1:0]   req_head_flat,
  input  logic [NPORTS*NPORTS-1:0]   req_ucast_dest_flat,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [NPORTS-1:0]          grant,
  output logic [NPORTS-1:0]          out_valid,
  output logic [NPORTS*NPORTS-1:0]   xbar_sel_flat,
  output logic                       err_drop,
  output logic                       resv_active,
  output logic [31:0]                stat_mcast_cnt,
  output logic [31:0]                stat_resv_cnt
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {ARB, RESV} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d, resv_idx_q, resv_idx_d;
  logic [NPORTS-1:0] reserved_q, reserved_d;
  logic [7:0]        wait_q [NPORTS];
  logic [7:0]        wait_d [NPORTS];

  logic [NPORTS-1:0] dest [NPORTS];
  logic [NPORTS-1:0] is_mcast;
  logic              head_unused;

  for (genvar g = 0; g < NPORTS; g++) begin : g_dec
    logic [NPORTS-1:0] mask;
    assign mask        = req_head_flat[g*FLIT_W + MCAST_MASK_LSB +: NPORTS];
    assign is_mcast[g] = req_head_flat[g*FLIT_W + MCAST_FLAG_BIT] && (mask != '0);
    assign dest[g]     = is_mcast[g] ? mask : req_ucast_dest_flat[g*NPORTS +: NPORTS];
  end
  // The rest of the head is payload that only the crossbar cares about.
  assign head_unused = ^req_head_flat;

  // Slot 0 is the reserved input (enabled only in RESV); slots 1.. follow rr_ptr.
  logic [PW-1:0] order    [NPORTS+1];
  logic          order_en [NPORTS+1];
  logic [PW:0]   scan_sum;

  always_comb begin
    scan_sum    = '0;
    order[0]    = resv_idx_q;
    order_en[0] = (state_q == RESV);
    for (int k = 0; k < NPORTS; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NPORTS)) scan_sum = scan_sum - (PW+1)'(NPORTS);
      order[k+1]    = scan_sum[PW-1:0];
      order_en[k+1] = !((state_q == RESV) && (scan_sum[PW-1:0] == resv_idx_q));
    end
  end

  logic [NPORTS-1:0]        grant_c, out_valid_c, used, resv_mask;
  logic [NPORTS*NPORTS-1:0] xbar_c;
  logic                     drop_c, any_grant, cand_ok;
  logic [PW-1:0]            first_idx, cand;

  always_comb begin
    grant_c     = '0;
    out_valid_c = '0;
    xbar_c      = '0;
    used        = '0;
    drop_c      = 1'b0;
    any_grant   = 1'b0;
    cand_ok     = 1'b0;
    first_idx   = '0;
    cand        = '0;
    resv_mask   = (state_q == RESV) ? reserved_q : '0;
    for (int k = 0; k <= NPORTS; k++) begin
      cand    = order[k];
      cand_ok = 1'b0;
      if (order_en[k] && req_valid[cand]) begin
        if (dest[cand] == '0) begin
          cand_ok = 1'b1;
          drop_c  = 1'b1;
        end else if (((dest[cand] & used) == '0) &&
                     ((dest[cand] & ~out_ready) == '0) &&
                     (((state_q == RESV) && (cand == resv_idx_q)) ||
                      ((dest[cand] & resv_mask) == '0))) begin
          cand_ok = 1'b1;
          used    = used | dest[cand];
          for (int o = 0; o < NPORTS; o++) begin
            if (dest[cand][o]) begin
              out_valid_c[o]                = 1'b1;
              xbar_c[o*NPORTS + int'(cand)] = 1'b1;
            end
          end
        end
      end
      if (cand_ok) begin
        grant_c[cand] = 1'b1;
        if (!any_grant) begin
          any_grant = 1'b1;
          first_idx = cand;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = (first_idx == PW'(NPORTS-1)) ? '0 : first_idx + 1'b1;
    for (int i = 0; i < NPORTS; i++) begin
      if (!req_valid[i] || grant_c[i])                      wait_d[i] = 8'd0;
      else if (is_mcast[i] && wait_q[i] < 8'(STARVE_LIMIT)) wait_d[i] = wait_q[i] + 8'd1;
      else                                                  wait_d[i] = wait_q[i];
    end
  end

  logic          resv_enter;
  logic [PW-1:0] starve_idx;

  always_comb begin
    state_d    = state_q;
    resv_idx_d = resv_idx_q;
    reserved_d = reserved_q;
    resv_enter = 1'b0;
    starve_idx = '0;
    case (state_q)
      ARB: begin
        for (int k = 1; k <= NPORTS; k++) begin
          starve_idx = order[k];
          if (!resv_enter && wait_q[starve_idx] == 8'(STARVE_LIMIT) &&
              req_valid[starve_idx] && !grant_c[starve_idx]) begin
            resv_enter = 1'b1;
            state_d    = RESV;
            resv_idx_d = starve_idx;
            reserved_d = dest[starve_idx];
          end
        end
      end
      RESV: if (grant_c[resv_idx_q] || !req_valid[resv_idx_q]) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      resv_idx_q <= '0;
      reserved_q <= '0;
      for (int i = 0; i < NPORTS; i++) wait_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      resv_idx_q <= resv_idx_d;
      reserved_q <= reserved_d;
      for (int i = 0; i < NPORTS; i++) wait_q[i] <= wait_d[i];
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  logic [31:0] mcast_cnt_q, resv_cnt_q, mcast_add;

  always_comb begin
    mcast_add = '0;
    for (int i = 0; i < NPORTS; i++) mcast_add = mcast_add + 32'(grant_c[i] & is_mcast[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcast_cnt_q <= '0;
      resv_cnt_q  <= '0;
    end else begin
      mcast_cnt_q <= mcast_cnt_q + mcast_add;
      resv_cnt_q  <= resv_cnt_q + 32'(resv_enter);
    end
  end

  assign stat_mcast_cnt = rst_n ? mcast_cnt_q : '0;
  assign stat_resv_cnt  = rst_n ? resv_cnt_q  : '0;
`else
  assign stat_mcast_cnt = '0;
  assign stat_resv_cnt  = '0;
`endif

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign grant         = rst_n ? grant_c     : '0;
  assign out_valid     = rst_n ? out_valid_c : '0;
  assign xbar_sel_flat = rst_n ? xbar_c      : '0;
  assign err_drop      = rst_n && drop_c;
  assign resv_active   = rst_n && (state_q == RESV);
endmodule

// File: tb/tb_router_mcast_arbiter.sv
// Directed bench for router_mcast_arbiter (STARVE_LIMIT=4); stat expectations follow ROUTER_ARB_STATS_EN.
module tb_router_mcast_arbiter;
`ifdef ROUTER_ARB_STATS_EN
  localparam logic [31:0] STATS = 32'd1;
`else
  localparam logic [31:0] STATS = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   req_valid, out_ready, grant, out_valid;
  logic [319:0] req_head_flat;
  logic [24:0]  req_ucast_dest_flat, xbar_sel_flat;
  logic         err_drop, resv_active;
  logic [31:0]  stat_mcast_cnt, stat_resv_cnt;
  int           total, bad;

  router_mcast_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_head_flat(req_head_flat),
    .req_ucast_dest_flat(req_ucast_dest_flat), .out_ready(out_ready), .grant(grant),
    .out_valid(out_valid), .xbar_sel_flat(xbar_sel_flat), .err_drop(err_drop),
    .resv_active(resv_active), .stat_mcast_cnt(stat_mcast_cnt), .stat_resv_cnt(stat_resv_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid           = '0;
    out_ready           = '0;
    req_head_flat       = '0;
    req_ucast_dest_flat = '0;
  endtask

  task automatic set_head(input int i, input logic mc, input logic [4:0] mask);
    req_head_flat[i*64 +: 64] = {32'h0, mc, mask, 26'h0};
  endtask

  task automatic set_ucast(input int i, input logic [4:0] d);
    req_ucast_dest_flat[i*5 +: 5] = d;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_ucast(0, 5'b00001);
    req_valid = 5'b00001;
    out_ready = 5'b11111;
    rst_n = 1'b0;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, err_drop, resv_active} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b ov=%b xbar=%h drop=%b resv=%b exp all 0",
               grant, out_valid, xbar_sel_flat, err_drop, resv_active);
    end
    total++;
    if ({stat_mcast_cnt, stat_resv_cnt} !== 64'd0) begin
      bad++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_mcast_cnt, stat_resv_cnt);
    end
    tick();
    rst_n = 1'b1;
    #3;
    total++;
    if ({grant, out_valid, resv_active} !== {5'b00001, 5'b00001, 1'b0}) begin
      bad++; $display("FAIL reset_release got grant=%b ov=%b resv=%b exp 00001/00001/0", grant, out_valid, resv_active);
    end
    tick();
  endtask

  task automatic test_unicast();
    apply_reset();
    set_ucast(0, 5'b00100);
    req_valid = 5'b00001;
    out_ready = 5'b11111;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, err_drop} !== {5'b00001, 5'b00100, 25'h400, 1'b0}) begin
      bad++; $display("FAIL uc_single got grant=%b ov=%b xbar=%h drop=%b exp 00001/00100/0000400/0",
                      grant, out_valid, xbar_sel_flat, err_drop);
    end
    tick();
    set_ucast(1, 5'b00100);
    req_valid = 5'b00011;
    #3;
    total++;
    if ({grant, xbar_sel_flat} !== {5'b00010, 25'h800}) begin
      bad++; $display("FAIL uc_rr_ptr1 got grant=%b xbar=%h exp 00010/0000800", grant, xbar_sel_flat);
    end
    tick();
    set_ucast(0, 5'b00001);
    set_ucast(1, 5'b00010);
    set_ucast(4, 5'b10000);
    req_valid = 5'b10011;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat} !== {5'b10011, 5'b10011, 25'h1000041}) begin
      bad++; $display("FAIL uc_parallel got grant=%b ov=%b xbar=%h exp 10011/10011/1000041",
                      grant, out_valid, xbar_sel_flat);
    end
    tick();
  endtask

  task automatic test_mcast_atomic();
    apply_reset();
    set_head(4, 1'b1, 5'b00111);
    req_valid = 5'b10000;
    out_ready = 5'b00101;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat} !== 35'd0) begin
      bad++; $display("FAIL mc_partial got grant=%b ov=%b xbar=%h exp all 0", grant, out_valid, xbar_sel_flat);
    end
    tick();
    out_ready = 5'b11111;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat} !== {5'b10000, 5'b00111, 25'h4210}) begin
      bad++; $display("FAIL mc_atomic got grant=%b ov=%b xbar=%h exp 10000/00111/0004210",
                      grant, out_valid, xbar_sel_flat);
    end
    tick();
    set_head(4, 1'b0, 5'b00000);
    set_head(1, 1'b1, 5'b00000);
    set_ucast(1, 5'b01000);
    req_valid = 5'b00010;
    #3;
    total++;
    if ({grant, out_valid, stat_mcast_cnt} !== {5'b00010, 5'b01000, STATS}) begin
      bad++; $display("FAIL mc_zero_mask got grant=%b ov=%b stat=%0d exp 00010/01000/%0d",
                      grant, out_valid, stat_mcast_cnt, STATS);
    end
    tick();
    req_valid = 5'b00000;
    #3;
    total++;
    if (stat_mcast_cnt !== STATS) begin
      bad++; $display("FAIL mc_stat_ucast got %0d exp %0d", stat_mcast_cnt, STATS);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] vld_seq [5];
    logic [4:0] exp_seq [5];
    apply_reset();
    set_ucast(0, 5'b00010);
    set_ucast(1, 5'b00010);
    set_ucast(4, 5'b00010);
    out_ready = 5'b11111;
    vld_seq[0] = 5'b00011; exp_seq[0] = 5'b00001;
    vld_seq[1] = 5'b00011; exp_seq[1] = 5'b00010;
    vld_seq[2] = 5'b00011; exp_seq[2] = 5'b00001;
    vld_seq[3] = 5'b10001; exp_seq[3] = 5'b10000;
    vld_seq[4] = 5'b10001; exp_seq[4] = 5'b00001;
    for (int c = 0; c < 5; c++) begin
      req_valid = vld_seq[c];
      #3;
      total++;
      if ({grant, out_valid} !== {exp_seq[c], 5'b00010}) begin
        bad++; $display("FAIL rr_cycle%0d got grant=%b ov=%b exp %b/00010", c, grant, out_valid, exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_drop();
    apply_reset();
    set_ucast(2, 5'b00000);
    req_valid = 5'b00100;
    out_ready = 5'b00000;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, err_drop} !== {5'b00100, 5'b00000, 25'h0, 1'b1}) begin
      bad++; $display("FAIL drop_single got grant=%b ov=%b xbar=%h drop=%b exp 00100/00000/0/1",
                      grant, out_valid, xbar_sel_flat, err_drop);
    end
    tick();
    set_ucast(3, 5'b00100);
    req_valid = 5'b01101;
    out_ready = 5'b11111;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, err_drop} !== {5'b01101, 5'b00100, 25'h2000, 1'b1}) begin
      bad++; $display("FAIL drop_multi got grant=%b ov=%b xbar=%h drop=%b exp 01101/00100/0002000/1",
                      grant, out_valid, xbar_sel_flat, err_drop);
    end
    tick();
    req_valid = 5'b00000;
    #3;
    total++;
    if (err_drop !== 1'b0) begin
      bad++; $display("FAIL drop_idle got %b exp 0", err_drop);
    end
  endtask

  // Alternating out0/out1 readiness keeps in3's two-output multicast from ever fitting.
  task automatic starve_prefix();
    apply_reset();
    set_head(3, 1'b1, 5'b00011);
    set_ucast(0, 5'b00001);
    set_ucast(1, 5'b00010);
    req_valid = 5'b01011;
    for (int c = 0; c < 5; c++) begin
      out_ready = c[0] ? 5'b11101 : 5'b11110;
      tick();
    end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_seq [5];
    exp_seq[0] = 5'b00010; exp_seq[1] = 5'b00001; exp_seq[2] = 5'b00010;
    exp_seq[3] = 5'b00001; exp_seq[4] = 5'b00010;
    apply_reset();
    set_head(3, 1'b1, 5'b00011);
    set_ucast(0, 5'b00001);
    set_ucast(1, 5'b00010);
    req_valid = 5'b01011;
    for (int c = 0; c < 5; c++) begin
      out_ready = c[0] ? 5'b11101 : 5'b11110;
      #3;
      total++;
      if ({grant, resv_active} !== {exp_seq[c], 1'b0}) begin
        bad++; $display("FAIL starve_cycle%0d got grant=%b resv=%b exp %b/0", c, grant, resv_active, exp_seq[c]);
      end
      tick();
    end
    out_ready = 5'b11110;
    #3;
    total++;
    if ({grant, out_valid, resv_active} !== {5'b00000, 5'b00000, 1'b1}) begin
      bad++; $display("FAIL starve_withheld got grant=%b ov=%b resv=%b exp 00000/00000/1", grant, out_valid, resv_active);
    end
    tick();
    out_ready = 5'b11111;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, resv_active} !== {5'b01000, 5'b00011, 25'h108, 1'b1}) begin
      bad++; $display("FAIL starve_serve got grant=%b ov=%b xbar=%h resv=%b exp 01000/00011/0000108/1",
                      grant, out_valid, xbar_sel_flat, resv_active);
    end
    tick();
    req_valid = 5'b00011;
    #3;
    total++;
    if ({grant, resv_active, stat_resv_cnt, stat_mcast_cnt} !== {5'b00011, 1'b0, STATS, STATS}) begin
      bad++; $display("FAIL starve_after got grant=%b resv=%b sresv=%0d smc=%0d exp 00011/0/%0d/%0d",
                      grant, resv_active, stat_resv_cnt, stat_mcast_cnt, STATS, STATS);
    end
    tick();
  endtask

  task automatic test_reset_mid_resv();
    starve_prefix();
    out_ready = 5'b11110;
    #3;
    total++;
    if (resv_active !== 1'b1) begin
      bad++; $display("FAIL mid_resv_setup got resv=%b exp 1", resv_active);
    end
    tick();
    rst_n = 1'b0;
    out_ready = 5'b11111;
    #3;
    total++;
    if ({grant, out_valid, xbar_sel_flat, err_drop, resv_active, stat_resv_cnt} !== 74'd0) begin
      bad++; $display("FAIL mid_resv_reset got grant=%b ov=%b xbar=%h drop=%b resv=%b sresv=%0d exp all 0",
                      grant, out_valid, xbar_sel_flat, err_drop, resv_active, stat_resv_cnt);
    end
    tick();
    rst_n = 1'b1;
    #3;
    total++;
    if ({grant, resv_active, stat_resv_cnt} !== {5'b00011, 1'b0, 32'd0}) begin
      bad++; $display("FAIL mid_resv_resume got grant=%b resv=%b sresv=%0d exp 00011/0/0",
                      grant, resv_active, stat_resv_cnt);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_unicast();
    test_mcast_atomic();
    test_round_robin();
    test_drop();
    test_starvation();
    test_reset_mid_resv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
